// File: rtl/spi_slave_xfer.sv
// SPI slave: synchronised pins, CPOL/CPHA-selectable word transfer with a single-entry tx buffer,
// per-word rx strobe, tx underrun and frame-abort status pulses.
module spi_slave_xfer #(
  parameter int unsigned      WIDTH       = 8,
  parameter bit               CPOL        = 1'b0,
  parameter bit               CPHA        = 1'b0,
  parameter int unsigned      SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] FILL        = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             SCLK,
  input  logic             MOSI,
  input  logic             CE0,
  output logic             MISO,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             busy,
  output logic             tx_underrun,
  output logic             frame_abort
);

  localparam int unsigned     CW        = $clog2(WIDTH);
  localparam logic [CW-1:0]   CntMax    = CW'(WIDTH - 1);
  localparam logic [1:0]      SettleMax = 2'(SYNC_STAGES);

  typedef enum logic [1:0] {StIdle, StActive, StWaitDesel} state_t;

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_mosi_sync, r_ce_sync;
  logic                   r_sclk_prev, r_ce_prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sclk_sync <= {SYNC_STAGES{CPOL}};
      r_mosi_sync <= '0;
      r_ce_sync   <= '1;
      r_sclk_prev <= CPOL;
      r_ce_prev   <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SCLK};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
      r_ce_sync   <= {r_ce_sync[SYNC_STAGES-2:0], CE0};
      r_sclk_prev <= r_sclk_sync[SYNC_STAGES-1];
      r_ce_prev   <= r_ce_sync[SYNC_STAGES-1];
    end
  end

  logic w_sclk, w_mosi, w_ce;
  logic w_rise, w_fall, w_lead, w_trail, w_sample, w_shift, w_ce_fall, w_last, w_word_done;
  logic [WIDTH-1:0] w_load_data;
  logic             w_load_under;

  state_t           r_state;
  logic [1:0]       r_settle;
  logic [WIDTH-1:0] r_tx_shift;
  logic [WIDTH-2:0] r_rx_shift;
  logic [WIDTH-1:0] r_rx_data;
  logic [WIDTH-1:0] r_buf;
  logic             r_buf_full;
  logic [CW-1:0]    r_bit_cnt;
  logic             r_load_pend;
  logic             r_rx_valid, r_underrun, r_abort;

  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
  assign w_ce        = r_ce_sync[SYNC_STAGES-1];
  assign w_rise      = w_sclk & ~r_sclk_prev;
  assign w_fall      = ~w_sclk & r_sclk_prev;
  assign w_lead      = CPOL ? w_fall : w_rise;
  assign w_trail     = CPOL ? w_rise : w_fall;
  assign w_sample    = CPHA ? w_trail : w_lead;
  assign w_shift     = CPHA ? w_lead : w_trail;
  assign w_ce_fall   = r_ce_prev & ~w_ce;
  assign w_last      = (r_bit_cnt == CntMax);
  assign w_word_done = w_sample & w_last;

  // Load priority: buffered word, then a word offered in this very cycle, then FILL.
  assign w_load_data  = r_buf_full ? r_buf : (tx_valid ? tx_data : FILL);
  assign w_load_under = ~r_buf_full & ~tx_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= StWaitDesel;
      r_settle    <= '0;
      r_tx_shift  <= '0;
      r_rx_shift  <= '0;
      r_rx_data   <= '0;
      r_buf       <= '0;
      r_buf_full  <= 1'b0;
      r_bit_cnt   <= '0;
      r_load_pend <= 1'b0;
      r_rx_valid  <= 1'b0;
      r_underrun  <= 1'b0;
      r_abort     <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_underrun <= 1'b0;
      r_abort    <= 1'b0;
      if (r_settle != SettleMax) r_settle <= r_settle + 2'd1;
      if (tx_valid && !r_buf_full) begin
        r_buf      <= tx_data;
        r_buf_full <= 1'b1;
      end
      unique case (r_state)
        StWaitDesel: begin
          // Decide only once the synchroniser reflects the pin, so a live frame is skipped.
          if (r_settle == SettleMax && w_ce) r_state <= StIdle;
        end
        StIdle: begin
          if (w_ce_fall) begin
            r_state     <= StActive;
            r_bit_cnt   <= '0;
            r_load_pend <= 1'b0;
            r_tx_shift  <= w_load_data;
            r_underrun  <= w_load_under;
            r_buf_full  <= 1'b0;
          end
        end
        StActive: begin
          if (w_sample) begin
            r_rx_shift <= {r_rx_shift[WIDTH-3:0], w_mosi};
            if (w_last) begin
              r_bit_cnt   <= '0;
              r_rx_data   <= {r_rx_shift, w_mosi};
              r_rx_valid  <= 1'b1;
              r_load_pend <= 1'b1;
            end else begin
              r_bit_cnt <= r_bit_cnt + CW'(1);
            end
          end
          if (w_ce) begin
            r_state     <= StIdle;
            r_tx_shift  <= '0;
            r_load_pend <= 1'b0;
            r_bit_cnt   <= '0;
            r_abort     <= (r_bit_cnt != '0 || w_sample) && !w_word_done;
          end else if (w_shift) begin
            if (r_load_pend) begin
              r_load_pend <= 1'b0;
              r_tx_shift  <= w_load_data;
              r_underrun  <= w_load_under;
              r_buf_full  <= 1'b0;
            end else if (r_bit_cnt != '0) begin
              r_tx_shift <= {r_tx_shift[WIDTH-2:0], 1'b0};
            end
          end
        end
        default: r_state <= StWaitDesel;
      endcase
    end
  end

  assign MISO        = r_tx_shift[WIDTH-1];
  assign tx_ready    = ~r_buf_full;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign busy        = (r_state == StActive);
  assign tx_underrun = r_underrun;
  assign frame_abort = r_abort;

endmodule

// File: tb/tb_spi_slave_xfer.sv
// Directed bench for spi_slave_xfer: dut0 mode 0 FILL=0xFF, dut1 mode 3 with 3 sync stages,
// dut2 16-bit mode 0. A vector table drives whole frames; hand sequences cover the corner cases.
`timescale 1ns/1ps
module tb_spi_slave_xfer;
  localparam int H = 80;  // SCLK half period: 8 clk cycles

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclk [3];
  logic mosi [3];
  logic ce0 [3];
  logic miso [3];
  logic [15:0] tx_d [3];
  logic tx_v [3];
  logic tx_rdy [3];
  logic [7:0] rx0, rx1;
  logic [15:0] rx2;
  logic [15:0] rx_dat [3];
  logic rxv [3], bsy [3], und [3], abt [3];

  int rxv_cnt [3] = '{0, 0, 0};
  int und_cnt [3] = '{0, 0, 0};
  int abt_cnt [3] = '{0, 0, 0};
  logic [31:0] rx_hist [3] = '{32'h0, 32'h0, 32'h0};
  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign rx_dat[0] = {8'h00, rx0};
  assign rx_dat[1] = {8'h00, rx1};
  assign rx_dat[2] = rx2;

  spi_slave_xfer #(.WIDTH(8), .CPOL(1'b0), .CPHA(1'b0), .SYNC_STAGES(2), .FILL(8'hFF)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .SCLK(sclk[0]), .MOSI(mosi[0]), .CE0(ce0[0]), .MISO(miso[0]),
    .tx_data(tx_d[0][7:0]), .tx_valid(tx_v[0]), .tx_ready(tx_rdy[0]), .rx_data(rx0),
    .rx_valid(rxv[0]), .busy(bsy[0]), .tx_underrun(und[0]), .frame_abort(abt[0]));

  spi_slave_xfer #(.WIDTH(8), .CPOL(1'b1), .CPHA(1'b1), .SYNC_STAGES(3), .FILL(8'h00)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .SCLK(sclk[1]), .MOSI(mosi[1]), .CE0(ce0[1]), .MISO(miso[1]),
    .tx_data(tx_d[1][7:0]), .tx_valid(tx_v[1]), .tx_ready(tx_rdy[1]), .rx_data(rx1),
    .rx_valid(rxv[1]), .busy(bsy[1]), .tx_underrun(und[1]), .frame_abort(abt[1]));

  spi_slave_xfer #(.WIDTH(16), .CPOL(1'b0), .CPHA(1'b0), .SYNC_STAGES(2), .FILL(16'h0000)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .SCLK(sclk[2]), .MOSI(mosi[2]), .CE0(ce0[2]), .MISO(miso[2]),
    .tx_data(tx_d[2]), .tx_valid(tx_v[2]), .tx_ready(tx_rdy[2]), .rx_data(rx2),
    .rx_valid(rxv[2]), .busy(bsy[2]), .tx_underrun(und[2]), .frame_abort(abt[2]));

  // Pulse monitors: one count per high cycle, so a stretched strobe shows up as an extra count.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rxv[d]) begin
        rxv_cnt[d] <= rxv_cnt[d] + 1;
        rx_hist[d] <= {rx_hist[d][15:0], rx_dat[d]};
      end
      if (und[d]) und_cnt[d] <= und_cnt[d] + 1;
      if (abt[d]) abt_cnt[d] <= abt_cnt[d] + 1;
    end
  end

  typedef struct {
    int          d;
    int          nb;
    logic [31:0] mosi_w;
    bit          pre;
    logic [15:0] pre_w;
    bit          mid;
    logic [15:0] mid_w;
    logic [31:0] e_miso;
    int          e_rxv;
    logic [15:0] e_rx;
    int          e_und;
    int          e_abt;
  } vec_t;

  vec_t vt [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input int d, input logic [15:0] w);
    bit done;
    done = 1'b0;
    @(negedge clk);
    tx_d[d] = w;
    tx_v[d] = 1'b1;
    for (int i = 0; i < 64 && !done; i++) begin
      if (tx_rdy[d]) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    tx_v[d] = 1'b0;
    n_vec++;
    if (!done) begin
      n_bad++;
      $display("FAIL push d%0d: tx_ready never high within 64 cycles, required high", d);
    end
  endtask

  task automatic bit_xfer(input int d, input logic b, output logic m);
    if (d == 1) begin
      sclk[d] = 1'b0;
      mosi[d] = b;
      #H;
      m = miso[d];
      sclk[d] = 1'b1;
      #H;
    end else begin
      mosi[d] = b;
      #H;
      m = miso[d];
      sclk[d] = 1'b1;
      #H;
      sclk[d] = 1'b0;
    end
  endtask

  task automatic frame_bits(input int d, input int nb, input logic [31:0] w,
                            output logic [31:0] cap);
    logic m;
    cap = '0;
    for (int i = 0; i < nb; i++) begin
      bit_xfer(d, w[nb-1-i], m);
      cap = {cap[30:0], m};
    end
  endtask

  task automatic frame_end(input int d);
    #H;
    ce0[d] = 1'b1;
    #(4 * H);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: run still going at 400000 ns, required to finish earlier");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    logic [31:0] cap;
    int r0, u0, a0;

    for (int d = 0; d < 3; d++) begin
      sclk[d] = (d == 1);
      mosi[d] = 1'b0;
      ce0[d]  = 1'b1;
      tx_v[d] = 1'b0;
      tx_d[d] = 16'h0;
    end
    //       d  nb  mosi      pre   pre_w     mid   mid_w     miso       rxv rx        und abt
    vt[0] = '{0, 8, 32'h3C,   1'b1, 16'hA5,   1'b0, 16'h0,    32'hA5,    1,  16'h3C,   1,  0};
    vt[1] = '{0, 8, 32'h81,   1'b0, 16'h0,    1'b1, 16'h77,   32'hFF,    1,  16'h81,   1,  0};
    vt[2] = '{0, 5, 32'h1C,   1'b1, 16'h96,   1'b0, 16'h0,    32'h12,    0,  16'h81,   0,  1};
    vt[3] = '{0, 8, 32'h00,   1'b0, 16'h0,    1'b0, 16'h0,    32'hFF,    1,  16'h00,   2,  0};
    vt[4] = '{0, 8, 32'hC7,   1'b1, 16'h5A,   1'b1, 16'h11,   32'h5A,    1,  16'hC7,   0,  0};
    vt[5] = '{1, 8, 32'h2B,   1'b1, 16'hE1,   1'b0, 16'h0,    32'hE1,    1,  16'h2B,   0,  0};
    vt[6] = '{1, 8, 32'hFF,   1'b0, 16'h0,    1'b0, 16'h0,    32'h00,    1,  16'hFF,   1,  0};
    vt[7] = '{1, 1, 32'h01,   1'b1, 16'h80,   1'b0, 16'h0,    32'h01,    0,  16'hFF,   0,  1};
    vt[8] = '{2, 16, 32'h1234, 1'b1, 16'hBEEF, 1'b1, 16'h0001, 32'hBEEF, 1,  16'h1234, 0,  0};

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("reset miso", {31'h0, miso[0]}, 32'h0);
    chk("reset rx_data", {16'h0, rx_dat[0]}, 32'h0);
    chk("reset rx_valid", {31'h0, rxv[0]}, 32'h0);
    chk("reset busy", {31'h0, bsy[0]}, 32'h0);
    chk("reset tx_ready", {31'h0, tx_rdy[0]}, 32'h1);
    chk("reset flags", {30'h0, und[0], abt[0]}, 32'h0);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);

    for (int k = 0; k < 9; k++) begin
      v = vt[k];
      if (v.pre) push(v.d, v.pre_w);
      r0 = rxv_cnt[v.d];
      u0 = und_cnt[v.d];
      a0 = abt_cnt[v.d];
      ce0[v.d] = 1'b0;
      #H;
      if (v.mid) push(v.d, v.mid_w);
      frame_bits(v.d, v.nb, v.mosi_w, cap);
      frame_end(v.d);
      chk($sformatf("v%0d miso", k), cap, v.e_miso);
      chk($sformatf("v%0d rx_valid count", k), rxv_cnt[v.d] - r0, v.e_rxv);
      chk($sformatf("v%0d rx_data", k), {16'h0, rx_dat[v.d]}, {16'h0, v.e_rx});
      chk($sformatf("v%0d underrun count", k), und_cnt[v.d] - u0, v.e_und);
      chk($sformatf("v%0d abort count", k), abt_cnt[v.d] - a0, v.e_abt);
    end

    // Mode 3, two back-to-back words in one frame, second tx word supplied mid-frame.
    push(1, 16'hC3);
    r0 = rxv_cnt[1];
    u0 = und_cnt[1];
    ce0[1] = 1'b0;
    #H;
    push(1, 16'h5A);
    frame_bits(1, 16, 32'h1234, cap);
    frame_end(1);
    chk("b2b miso", cap, 32'hC35A);
    chk("b2b rx_valid count", rxv_cnt[1] - r0, 2);
    chk("b2b rx words", rx_hist[1], 32'h0012_0034);
    chk("b2b underrun count", und_cnt[1] - u0, 0);

    // 16-bit direct load: tx_valid offered only in the IDLE->ACTIVE load cycle.
    u0 = und_cnt[2];
    r0 = rxv_cnt[2];
    @(posedge clk);
    #1 ce0[2] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    tx_d[2] = 16'hA55A;
    tx_v[2] = 1'b1;
    @(negedge clk);
    chk("direct tx_ready in load cycle", {31'h0, tx_rdy[2]}, 32'h1);
    @(posedge clk);
    #1 tx_v[2] = 1'b0;
    @(negedge clk);
    chk("direct buffer left empty", {31'h0, tx_rdy[2]}, 32'h1);
    chk("direct busy", {31'h0, bsy[2]}, 32'h1);
    #H;
    push(2, 16'h0F0F);
    frame_bits(2, 16, 32'h8001, cap);
    frame_end(2);
    chk("direct miso", cap, 32'hA55A);
    chk("direct underrun count", und_cnt[2] - u0, 0);
    chk("direct rx_data", {16'h0, rx_dat[2]}, 32'h8001);
    chk("direct rx_valid count", rxv_cnt[2] - r0, 1);

    // Reset pulsed mid-frame on dut0; the rest of that frame must be ignored.
    push(0, 16'h3C);
    ce0[0] = 1'b0;
    #H;
    push(0, 16'h77);
    frame_bits(0, 3, 32'h5, cap);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("midrst miso", {31'h0, miso[0]}, 32'h0);
    chk("midrst rx_data", {16'h0, rx_dat[0]}, 32'h0);
    chk("midrst busy", {31'h0, bsy[0]}, 32'h0);
    chk("midrst tx_ready", {31'h0, tx_rdy[0]}, 32'h1);
    chk("midrst flags", {30'h0, und[0], abt[0]}, 32'h0);
    rst_n = 1'b1;
    r0 = rxv_cnt[0];
    a0 = abt_cnt[0];
    frame_bits(0, 5, 32'h1F, cap);
    chk("midrst busy after release", {31'h0, bsy[0]}, 32'h0);
    chk("midrst miso after release", cap, 32'h0);
    frame_end(0);
    chk("midrst rx_valid count", rxv_cnt[0] - r0, 0);
    chk("midrst abort count", abt_cnt[0] - a0, 0);

    push(0, 16'h69);
    r0 = rxv_cnt[0];
    u0 = und_cnt[0];
    ce0[0] = 1'b0;
    #H;
    push(0, 16'h22);
    frame_bits(0, 8, 32'h96, cap);
    frame_end(0);
    chk("post-reset miso", cap, 32'h69);
    chk("post-reset rx_data", {16'h0, rx_dat[0]}, 32'h96);
    chk("post-reset rx_valid count", rxv_cnt[0] - r0, 1);
    chk("post-reset underrun count", und_cnt[0] - u0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
